// File: rtl/shift_pkg.sv
// Shared op codes and FSM encodings for the multi-cycle shifter.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/handshake/result bundle between the ALU control and seq_shifter.
interface seq_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (output start, op, a, shamt, input busy, done, result);
    modport slave  (input start, op, a, shamt, output busy, done, result);
endinterface

// File: rtl/shift_step.sv
// One bounded shift of 0..STEP positions for any of the four ops.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [KW-1:0]    k,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] dout
);

    logic [2*WIDTH-1:0] dbl;

    always_comb begin
        // low half of the doubled word is the rotate-right result
        dbl = {din, din} >> k;
        case (op)
            OP_SLL:  dout = din << k;
            OP_SRL:  dout = din >> k;
            OP_SRA:  dout = WIDTH'($signed(din) >>> k);
            default: dout = dbl[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR unit, up to STEP bit positions per cycle.
//  state   | meaning
//  S_IDLE  | waiting for start; result holds the last value
//  S_SHIFT | acc shifted by min(remaining, STEP) each cycle
//  S_DONE  | one-cycle done pulse, result valid
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    seq_shifter_if.slave  bus
);

    localparam int KW = $clog2(STEP + 1);

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] remaining;
    logic [WIDTH-1:0]   result_q;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_out;

    always_comb begin
        if (int'(remaining) < STEP) k = KW'(remaining);
        else                        k = KW'(STEP);
    end

    shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
        .din  (acc),
        .k    (k),
        .op   (op_q),
        .dout (step_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_SLL;
            acc       <= '0;
            remaining <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q      <= bus.op;
                        acc       <= bus.a;
                        remaining <= bus.shamt;
                        if (bus.shamt == '0) begin
                            state    <= S_DONE;
                            result_q <= bus.a;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc       <= step_out;
                    remaining <= remaining - SHAMT_W'(k);
                    // k never exceeds remaining, so equality marks the last step
                    if (remaining == SHAMT_W'(k)) begin
                        state    <= S_DONE;
                        result_q <= step_out;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == S_SHIFT) || (state == S_DONE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and random checks of seq_shifter at STEP = 1, 4 and 32 (WIDTH = 32).
module tb_seq_shifter;

    localparam int STEPS [3] = '{1, 4, 32};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        drv_start = 1'b0;
    logic [1:0]  drv_op = 2'b00;
    logic [31:0] drv_a = '0;
    logic [4:0]  drv_sh = '0;
    logic [2:0]  done_v, busy_v;
    logic [31:0] res_v [3];
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    seq_shifter_if #(.WIDTH(32)) bus0 ();
    seq_shifter_if #(.WIDTH(32)) bus1 ();
    seq_shifter_if #(.WIDTH(32)) bus2 ();

    seq_shifter #(.WIDTH(32), .STEP(1))  u_s1  (.clk(clk), .reset(reset), .bus(bus0));
    seq_shifter #(.WIDTH(32), .STEP(4))  u_s4  (.clk(clk), .reset(reset), .bus(bus1));
    seq_shifter #(.WIDTH(32), .STEP(32)) u_s32 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus0.start = drv_start;  assign bus0.op = drv_op;
    assign bus0.a     = drv_a;      assign bus0.shamt = drv_sh;
    assign bus1.start = drv_start;  assign bus1.op = drv_op;
    assign bus1.a     = drv_a;      assign bus1.shamt = drv_sh;
    assign bus2.start = drv_start;  assign bus2.op = drv_op;
    assign bus2.a     = drv_a;      assign bus2.shamt = drv_sh;
    assign done_v = {bus2.done, bus1.done, bus0.done};
    assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
    assign res_v[0] = bus0.result;
    assign res_v[1] = bus1.result;
    assign res_v[2] = bus2.result;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] av, input int sh);
        case (o)
            2'b00:   return av << sh;
            2'b01:   return av >> sh;
            2'b10:   return $signed(av) >>> sh;
            default: return (sh == 0) ? av : ((av >> sh) | (av << (32 - sh)));
        endcase
    endfunction

    // Runs one op on all three DUTs; exp_lat4 is the hand latency for STEP=4.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] sh, input logic [31:0] exp_res, input int exp_lat4);
        int lat [3];
        int ndone [3];
        int nbusy [3];
        logic [31:0] got [3];
        int exp_lat;
        for (int d = 0; d < 3; d++) begin
            lat[d] = 0; ndone[d] = 0; nbusy[d] = 0; got[d] = '0;
        end
        @(negedge clk);
        drv_start = 1'b1; drv_op = o; drv_a = av; drv_sh = sh;
        @(posedge clk);
        #1;
        drv_start = 1'b0; drv_op = ~o; drv_a = ~av; drv_sh = ~sh;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (done_v[d]) begin
                    if (lat[d] == 0) begin
                        lat[d] = cyc;
                        got[d] = res_v[d];
                    end
                    ndone[d]++;
                end
                if (busy_v[d]) nbusy[d]++;
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && done_v == 3'b000) break;
        end
        for (int d = 0; d < 3; d++) begin
            exp_lat = (d == 1) ? exp_lat4 : (int'(sh) + STEPS[d] - 1) / STEPS[d] + 1;
            chk($sformatf("%s_res_s%0d", tag, STEPS[d]), got[d], exp_res);
            chk($sformatf("%s_lat_s%0d", tag, STEPS[d]), lat[d], exp_lat);
            chk($sformatf("%s_pulse_s%0d", tag, STEPS[d]), ndone[d], 1);
            chk($sformatf("%s_busy_s%0d", tag, STEPS[d]), nbusy[d], exp_lat);
        end
    endtask

    initial begin
        int cnt;
        int lat;
        bit seen;
        logic [1:0] ro;
        logic [31:0] ra;
        logic [4:0] rs;

        // reset state, then reset aborting an in-flight SRA
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy_v[1], 0);
        chk("rst_done", done_v[1], 0);
        chk("rst_result", res_v[1], 0);
        @(negedge clk);
        drv_start = 1'b1; drv_op = 2'b10; drv_a = 32'h8000_0010; drv_sh = 5'd31;
        @(posedge clk);
        #1 drv_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("abort_busy_s%0d", STEPS[d]), busy_v[d], 0);
            chk($sformatf("abort_done_s%0d", STEPS[d]), done_v[d], 0);
            chk($sformatf("abort_result_s%0d", STEPS[d]), res_v[d], 0);
        end

        run_op("sra5",  2'b10, 32'h8000_0010, 5'd5,  32'hFC00_0000, 3);
        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9);
        run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9);
        run_op("ror4",  2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F, 2);
        run_op("ror0",  2'b11, 32'h0000_00F1, 5'd0,  32'h0000_00F1, 1);
        run_op("sra0",  2'b10, 32'h8765_4321, 5'd0,  32'h8765_4321, 1);

        // starts held high while busy are ignored; the IDLE-cycle start is accepted
        @(negedge clk);
        drv_start = 1'b1; drv_op = 2'b00; drv_a = 32'h0000_0001; drv_sh = 5'd8;
        @(posedge clk);
        #1;
        drv_op = 2'b10; drv_a = 32'hFFFF_FFFF; drv_sh = 5'd3;
        seen = 1'b0;
        for (cnt = 1; cnt <= 20; cnt++) begin
            @(negedge clk);
            if (done_v[1]) begin
                chk("ign_res", res_v[1], 32'h0000_0100);
                chk("ign_lat", cnt, 3);
                seen = 1'b1;
            end else if (seen && !busy_v[1]) begin
                break;
            end
        end
        chk("ign_seen", seen, 1);
        chk("ign_idle_res", res_v[1], 32'h0000_0100);
        @(posedge clk);
        #1 drv_start = 1'b0;
        @(negedge clk);
        chk("back2back_busy", busy_v[1], 1);
        lat = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (done_v[1] && lat == 0) begin
                lat = c;
                chk("back2back_res", res_v[1], 32'hFFFF_FFFF);
            end
        end
        chk("back2back_lat", lat, 2);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 2000; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            run_op("rnd", ro, ra, rs, model(ro, ra, int'(rs)), (int'(rs) + 3) / 4 + 1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
